regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register index width; NREGS = 2**ADDR_W.
REQ-003 The block SHALL have parameter NREAD, default 2, number of read ports (1..8).
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port ctrl_reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port ctrl_writeEnable, input, 1, write strobe.
REQ-007 The block SHALL have port ctrl_writeReg, input, ADDR_W, write index.
REQ-008 The block SHALL have port data_writeReg, input, DATA_W, write data.
REQ-009 The block SHALL have port ctrl_reserve, input, 1, scoreboard reserve strobe (pending write issued).
REQ-010 The block SHALL have port ctrl_reserveReg, input, ADDR_W, index to reserve.
REQ-011 The block SHALL have port ctrl_readReg, input, NREAD*ADDR_W, packed read indices; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-012 The block SHALL have port data_readReg, output, NREAD*DATA_W, packed read data, same packing.
REQ-013 The block SHALL have port busy_read, output, NREAD, per-port pending-write flag.
REQ-014 The block SHALL have port reserve_conflict, output, 1, combinational: ctrl_reserve high and target already busy.
REQ-015 The block SHALL have port busy_count, output, ADDR_W+1, number of busy registers.
REQ-016 The block SHALL have ports ctrl_dbgSel (input, ADDR_W) and data_dbg (output, DATA_W), the combinational debug tap of the selected register.

Function
REQ-017 Register 0 SHALL read as zero, ignore writes, never be busy, and ignore reservations.
REQ-018 A write to register r != 0 SHALL update it at the rising edge while ctrl_writeEnable is high, and SHALL clear busy[r] at that edge.
REQ-019 A reserve of r != 0 SHALL set busy[r] at the rising edge.
REQ-020 When a write and a reserve target the same r in one cycle, busy[r] SHALL end at 1 (the new pending write wins).
REQ-021 A reserve of an already-busy r SHALL assert reserve_conflict that cycle and leave busy[r] at 1; the count SHALL be unchanged.
REQ-022 busy_count SHALL be a registered counter, adjusted by -1, 0 or +1 per edge, exactly equal to popcount(busy) after every edge; it SHALL never wrap.
REQ-023 Reads SHALL be combinational from the stored array; no read port SHALL ever drive high-impedance.
REQ-024 busy_read[k] SHALL equal busy at port k's index, unless overridden by REQ-027.

Reset
REQ-025 While ctrl_reset is high, all registers, all busy bits and busy_count SHALL be 0 immediately, independent of clock; strobes SHALL be ignored.
REQ-026 With reset asserted mid-operation, every read port and data_dbg SHALL output 0, and busy_read and reserve_conflict SHALL output 0.

Configuration
REQ-027 With REGFILE_BYPASS_EN defined, a read port whose index equals ctrl_writeReg (!= 0) while ctrl_writeEnable is high SHALL return data_writeReg, and its busy_read SHALL be 0.
REQ-028 Without REGFILE_BYPASS_EN, reads SHALL return the pre-edge stored value and the registered busy flag; there SHALL be no forwarding logic.

Structure
REQ-029 The default widths and the packing helper constants SHALL live in the shared package regfile_pkg.
REQ-030 Busy tracking and the counter SHALL be the sub-module regfile_scoreboard; the storage, read muxes and bypass SHALL stay in regfile_mp.

Verification
REQ-031 The bench SHALL cover: reset, then write r5=0xDEADBEEF, then read port0 r5 next cycle -> 0xDEADBEEF; writing r0=0x1 -> r0 reads 0.
REQ-032 The bench SHALL cover: reserve r7 -> busy_read=1 and busy_count=1; write r7=0x55 -> busy 0 and count 0.
REQ-033 The bench SHALL cover: same-cycle write r9 and reserve r9 -> busy[9]=1 and count unchanged at 1; reserving r9 again -> reserve_conflict=1.
REQ-034 The bench SHALL cover: with REGFILE_BYPASS_EN, a same-cycle write r3=0xA5A5A5A5 with port1 reading r3 -> port1=0xA5A5A5A5 and busy_read[1]=0; without the macro -> the old value.
REQ-035 The bench SHALL cover: reserve r1..r31 -> count 31; assert ctrl_reset between edges -> all outputs 0 at once.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and packing helper for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREAD  = 2;

  // Low bit of lane k in a packed bus of w-bit lanes.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file port bundle: write, reserve, packed reads, scoreboard status, debug tap.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD  = DEF_NREAD
) ();

  logic                      ctrl_writeEnable;
  logic [ADDR_W-1:0]         ctrl_writeReg;
  logic [DATA_W-1:0]         data_writeReg;
  logic                      ctrl_reserve;
  logic [ADDR_W-1:0]         ctrl_reserveReg;
  logic [NREAD*ADDR_W-1:0]   ctrl_readReg;
  logic [NREAD*DATA_W-1:0]   data_readReg;
  logic [NREAD-1:0]          busy_read;
  logic                      reserve_conflict;
  logic [ADDR_W:0]           busy_count;
  logic [ADDR_W-1:0]         ctrl_dbgSel;
  logic [DATA_W-1:0]         data_dbg;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           ctrl_reserve, ctrl_reserveReg, ctrl_readReg, ctrl_dbgSel,
    input  data_readReg, busy_read, reserve_conflict, busy_count, data_dbg
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           ctrl_reserve, ctrl_reserveReg, ctrl_readReg, ctrl_dbgSel,
    output data_readReg, busy_read, reserve_conflict, busy_count, data_dbg
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: per-register busy bits and a running busy count.
module regfile_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_reg,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_reg,
  output logic [2**ADDR_W-1:0]   busy,
  output logic [ADDR_W:0]        busy_count,
  output logic                   reserve_conflict
);

  localparam int NREGS = 2**ADDR_W;

  logic             wr_hit, rsv_hit, set_new, clr_old;
  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    wr_hit   = wr_en  && (wr_reg  != '0);
    rsv_hit  = rsv_en && (rsv_reg != '0);
    // Count moves only on real 0->1 / 1->0 transitions; a write and a
    // reserve of the same busy register leave it busy with no net change.
    set_new  = rsv_hit && !busy[rsv_reg];
    clr_old  = wr_hit && busy[wr_reg] && !(rsv_hit && (rsv_reg == wr_reg));
    busy_nxt = busy;
    if (wr_hit)  busy_nxt[wr_reg]  = 1'b0;
    if (rsv_hit) busy_nxt[rsv_reg] = 1'b1;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy <= busy_nxt;
      if (set_new && !clr_old)      busy_count <= busy_count + 1'b1;
      else if (clr_old && !set_new) busy_count <= busy_count - 1'b1;
    end
  end

  assign reserve_conflict = rsv_hit && busy[rsv_reg];

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending-write scoreboard.
// Optional same-cycle write forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD  = DEF_NREAD
) (
  input logic          clock,
  input logic          ctrl_reset,
  regfile_mp_if.slave  bus
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             busy;
  logic [NREAD-1:0][DATA_W-1:0] rd_data;
  logic [NREAD-1:0]             rd_busy;
  logic [ADDR_W-1:0]            idx;

  // Register 0 is never written, so it holds its reset zero forever.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset)
      regs <= '0;
    else if (bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0))
      regs[bus.ctrl_writeReg] <= bus.data_writeReg;
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .wr_en            (bus.ctrl_writeEnable),
    .wr_reg           (bus.ctrl_writeReg),
    .rsv_en           (bus.ctrl_reserve),
    .rsv_reg          (bus.ctrl_reserveReg),
    .busy             (busy),
    .busy_count       (bus.busy_count),
    .reserve_conflict (bus.reserve_conflict)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    idx     = '0;
    for (int k = 0; k < NREAD; k++) begin
      idx = bus.ctrl_readReg[lane_lo(k, ADDR_W) +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is held off during reset so every port reads zero.
      if (!ctrl_reset && bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0) &&
          (bus.ctrl_writeReg == idx)) begin
        rd_data[k] = bus.data_writeReg;
        rd_busy[k] = 1'b0;
      end else begin
        rd_data[k] = regs[idx];
        rd_busy[k] = busy[idx];
      end
`else
      rd_data[k] = regs[idx];
      rd_busy[k] = busy[idx];
`endif
    end
  end

  assign bus.data_readReg = rd_data;
  assign bus.busy_read    = rd_busy;
  assign bus.data_dbg     = regs[bus.ctrl_dbgSel];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: behavioural model + per-cycle compare + directed literals.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NREGS = 32;

  logic clock = 1'b0;
  logic ctrl_reset;
  int   n_cmp = 0;
  int   n_err = 0;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus.slave)
  );

  always #5 clock = ~clock;

  // Behavioural model: architectural register contents and pending-write set.
  logic [DW-1:0] mregs [NREGS];
  bit            mbusy [NREGS];

  always @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mregs[i] <= '0;
        mbusy[i] <= 1'b0;
      end
    end else begin
      if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 0) begin
        mregs[bus.ctrl_writeReg] <= bus.data_writeReg;
        mbusy[bus.ctrl_writeReg] <= 1'b0;
      end
      if (bus.ctrl_reserve && bus.ctrl_reserveReg != 0)
        mbusy[bus.ctrl_reserveReg] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    int            pop;
    int            idx;
    logic [DW-1:0] ed;
    logic          eb;
    pop = 0;
    for (int i = 0; i < NREGS; i++) pop += int'(mbusy[i]);
    for (int k = 0; k < NR; k++) begin
      idx = int'(bus.ctrl_readReg[k*AW +: AW]);
      ed  = (ctrl_reset || idx == 0) ? '0 : mregs[idx];
      eb  = ctrl_reset ? 1'b0 : mbusy[idx];
`ifdef REGFILE_BYPASS_EN
      if (!ctrl_reset && bus.ctrl_writeEnable && bus.ctrl_writeReg != 0 &&
          int'(bus.ctrl_writeReg) == idx) begin
        ed = bus.data_writeReg;
        eb = 1'b0;
      end
`endif
      chk($sformatf("cyc_rd%0d", k), 64'(bus.data_readReg[k*DW +: DW]), 64'(ed));
      chk($sformatf("cyc_busy%0d", k), 64'(bus.busy_read[k]), 64'(eb));
    end
    chk("cyc_count", 64'(bus.busy_count), 64'(ctrl_reset ? 0 : pop));
    chk("cyc_conflict", 64'(bus.reserve_conflict),
        64'(!ctrl_reset && bus.ctrl_reserve && bus.ctrl_reserveReg != 0 &&
            mbusy[bus.ctrl_reserveReg]));
    chk("cyc_dbg", 64'(bus.data_dbg), 64'(ctrl_reset ? '0 : mregs[bus.ctrl_dbgSel]));
  end

  task automatic tick();
    @(posedge clock);
    #2;
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_reserve     = 1'b0;
  endtask

  task automatic set_rd(input int k, input int r);
    bus.ctrl_readReg[k*AW +: AW] = AW'(r);
  endtask

  task automatic do_write(input int r, input logic [DW-1:0] d);
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = AW'(r);
    bus.data_writeReg    = d;
  endtask

  task automatic do_reserve(input int r);
    bus.ctrl_reserve    = 1'b1;
    bus.ctrl_reserveReg = AW'(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = '0;
    bus.data_writeReg    = '0;
    bus.ctrl_reserve     = 1'b0;
    bus.ctrl_reserveReg  = '0;
    bus.ctrl_readReg     = '0;
    bus.ctrl_dbgSel      = 5'd5;
    ctrl_reset           = 1'b1;
    repeat (2) @(posedge clock);
    #3;
    chk("reset_count", 64'(bus.busy_count), 64'd0);
    chk("reset_rd", 64'(bus.data_readReg), 64'd0);
    ctrl_reset = 1'b0;

    // r5 write, then read back; r0 write is dropped.
    tick();
    do_write(5, 32'hDEADBEEF);
    tick();
    set_rd(0, 5);
    #1 chk("r5_read", 64'(bus.data_readReg[DW-1:0]), 64'hDEADBEEF);
    do_write(0, 32'h1);
    tick();
    set_rd(0, 0);
    #1 chk("r0_read", 64'(bus.data_readReg[DW-1:0]), 64'd0);

    // Reserve r7 then retire it with a write.
    do_reserve(7);
    tick();
    set_rd(0, 7);
    #1 chk("r7_busy", 64'(bus.busy_read[0]), 64'd1);
    chk("r7_count", 64'(bus.busy_count), 64'd1);
    do_write(7, 32'h55);
    tick();
    #1 chk("r7_clear", 64'(bus.busy_read[0]), 64'd0);
    chk("r7_count0", 64'(bus.busy_count), 64'd0);
    chk("r7_data", 64'(bus.data_readReg[DW-1:0]), 64'h55);

    // r9: reserve, then write+reserve same cycle (stays busy), then conflict.
    do_reserve(9);
    tick();
    do_write(9, 32'h99);
    do_reserve(9);
    tick();
    set_rd(0, 9);
    #1 chk("r9_busy", 64'(bus.busy_read[0]), 64'd1);
    chk("r9_count", 64'(bus.busy_count), 64'd1);
    do_reserve(9);
    #1 chk("r9_conflict", 64'(bus.reserve_conflict), 64'd1);
    tick();
    #1 chk("r9_count_hold", 64'(bus.busy_count), 64'd1);

    // r3 forwarding case: old value 0x11111111, busy before the write.
    do_write(3, 32'h11111111);
    tick();
    do_reserve(3);
    tick();
    do_write(3, 32'hA5A5A5A5);
    set_rd(1, 3);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("r3_port1", 64'(bus.data_readReg[DW +: DW]), 64'hA5A5A5A5);
    chk("r3_busy1", 64'(bus.busy_read[1]), 64'd0);
`else
    chk("r3_port1", 64'(bus.data_readReg[DW +: DW]), 64'h11111111);
    chk("r3_busy1", 64'(bus.busy_read[1]), 64'd1);
`endif
    tick();
    #1 chk("r3_after", 64'(bus.data_readReg[DW +: DW]), 64'hA5A5A5A5);
    chk("r3_count", 64'(bus.busy_count), 64'd1);

    // Reserve every register: count saturates at 31 (r9 already busy).
    for (int r = 1; r < NREGS; r++) begin
      do_reserve(r);
      tick();
    end
    set_rd(0, 31);
    set_rd(1, 9);
    #1 chk("all_count", 64'(bus.busy_count), 64'd31);
    chk("all_busy", 64'(bus.busy_read), 64'd3);

    // Mid-cycle reset with active strobes: everything drops to zero at once.
    tick();
    do_write(5, 32'h12345678);
    do_reserve(5);
    set_rd(0, 5);
    bus.ctrl_dbgSel = 5'd5;
    #1 chk("pre_rst_conflict", 64'(bus.reserve_conflict), 64'd1);
    ctrl_reset = 1'b1;
    #1;
    chk("rst_rd", 64'(bus.data_readReg), 64'd0);
    chk("rst_busy", 64'(bus.busy_read), 64'd0);
    chk("rst_conflict", 64'(bus.reserve_conflict), 64'd0);
    chk("rst_count", 64'(bus.busy_count), 64'd0);
    chk("rst_dbg", 64'(bus.data_dbg), 64'd0);
    @(posedge clock);
    #2;
    chk("rst_edge_count", 64'(bus.busy_count), 64'd0);
    chk("rst_edge_rd", 64'(bus.data_readReg), 64'd0);
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_reserve     = 1'b0;
    ctrl_reset           = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
